fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Parametrised successor to the program counter / instruction memory / instruction decoder chain.
- Owns the PC and drives a synchronous 1-cycle-latency instruction memory.
- Decodes fetched words into opcode/reg_a/reg_b/imm fields and presents them downstream with a valid/ready handshake.
- Adds redirect (jump/call/return) with pipeline flush, a hardware return-address stack (RAS) and backpressure handling via a 2-entry decode buffer.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width
- INSTR_W, 16, instruction word width
- OPCODE_W, 4, opcode field width, taken from the MSBs
- REG_W, 4, width of each register-index field
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- jump_enable  in  1  redirect PC to jump_address
- call_enable  in  1  qualifies jump_enable: also push link_address onto the RAS
- jump_address  in  ADDR_W  redirect target
- link_address  in  ADDR_W  return address pushed on call
- return_enable  in  1  redirect PC to the popped RAS entry
- imem_enable  out  1  memory read strobe
- imem_address  out  ADDR_W  memory read address
- imem_instruction  in  INSTR_W  read data, valid the cycle after imem_enable
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts the entry
- out_pc  out  ADDR_W  address of the presented instruction
- opcode  out  OPCODE_W  instruction[INSTR_W-1 -: OPCODE_W]
- reg_a  out  REG_W  next REG_W bits below the opcode
- reg_b  out  REG_W  next REG_W bits below reg_a
- imm_value  out  IMM_W  remaining low bits, where IMM_W = INSTR_W-OPCODE_W-2*REG_W (must be >=1)
- ras_overflow  out  1  one-cycle pulse: push while full
- ras_underflow  out  1  one-cycle pulse: return while empty

Behaviour:
- Reset (reset==0 at an edge):
  - pc=RESET_PC; imem_enable=0; out_valid=0; all field outputs 0.
  - Buffer and RAS emptied; flag outputs 0; in-flight read discarded.
- Fetch:
  - imem_address=pc combinationally.
  - imem_enable=1 when (buffer_count + inflight) < 2 and no redirect this cycle.
  - On each issue, pc <= pc+1, wrapping mod 2^ADDR_W.
- Response:
  - The cycle after an issue, imem_instruction is written with its pc into the 2-entry FIFO, unless a redirect occurred in the issue-to-response window (epoch mismatch). In that case it is dropped.
- Output:
  - The FIFO head is decoded combinationally: fields and out_pc come from the head, out_valid = FIFO non-empty.
  - A transfer occurs when out_valid & out_ready. Fields stay stable while out_valid & !out_ready.
- Throughput and latency:
  - Sustained 1 instruction/cycle when out_ready is held high.
  - First out_valid appears 2 cycles after reset release.
- Redirect, priority jump_enable > return_enable:
  - pc <= target; FIFO cleared; epoch toggles.
  - No issue in the redirect cycle; the next issue is in the following cycle.
  - A transfer occurring in the redirect cycle is still counted as consumed.
- Call (jump_enable & call_enable): push link_address.
  - If full, the oldest entry is overwritten (circular) and ras_overflow pulses.
- Return (return_enable & !jump_enable): target = top of stack, then pop.
  - If empty, target=RESET_PC, no pop, ras_underflow pulses.
- call_enable without jump_enable is ignored.
- return_enable coincident with jump_enable is ignored; the RAS is unchanged.
- Reset mid-operation overrides everything.

Decomposition:
- Package fetch_decode_pkg holds:
  - field offset/width localparams and IMM_W derivation;
  - the elaboration check IMM_W>=1;
  - RESET_PC default;
  - redirect-priority encoding constants.
- Sub-module return_address_stack (parameters DEPTH, ADDR_W; push/pop/top/full/empty; circular overwrite; same clk/reset).

Test Plan:
- Reset, then release with memory holding 0x1234 at address 0 and out_ready=1 -> cycle 2: out_valid=1, out_pc=0, opcode=1, reg_a=2, reg_b=3, imm=4; consecutive addresses every cycle thereafter.
- out_ready=0 for 5 cycles mid-stream -> imem_enable drops after the FIFO fills; fields hold steady; no instruction lost or duplicated on release.
- jump_enable to 0x0040 while 2 entries are buffered and 1 is in flight -> stale entries never appear on the output; next out_pc=0x0040.
- Call to 0x0100 with link 0x0011, then return -> fetch resumes at 0x0011; RAS is empty afterwards.
- 5 calls with RAS_DEPTH=4 -> ras_overflow pulses once; 4 returns yield links 5,4,3,2; a 5th return pulses ras_underflow and targets RESET_PC.
- PC=0xFFFF with reset asserted mid-stall -> wrap to 0x0000 observed; reset clears out_valid and the FIFO the next edge.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg
//   Shared constants and helpers for the fetch/decode slice:
//   default parameter values, instruction field geometry helpers
//   (offsets and the derived immediate width), the field-fit check used
//   at elaboration, and the redirect-select encoding.
package fetch_decode_pkg;

    localparam int unsigned DEFAULT_ADDR_W    = 16;
    localparam int unsigned DEFAULT_INSTR_W   = 16;
    localparam int unsigned DEFAULT_OPCODE_W  = 4;
    localparam int unsigned DEFAULT_REG_W     = 4;
    localparam int unsigned DEFAULT_RAS_DEPTH = 4;
    localparam int unsigned DEFAULT_RESET_PC  = 0;

    // Redirect source select; jump outranks return.
    localparam logic [1:0] REDIR_NONE   = 2'b00;
    localparam logic [1:0] REDIR_JUMP   = 2'b01;
    localparam logic [1:0] REDIR_RETURN = 2'b10;

    function automatic int unsigned imm_width(input int unsigned instr_w,
                                              input int unsigned opcode_w,
                                              input int unsigned reg_w);
        return instr_w - opcode_w - 2 * reg_w;
    endfunction

    // Immediate field must keep at least one bit.
    function automatic bit fields_fit(input int unsigned instr_w,
                                      input int unsigned opcode_w,
                                      input int unsigned reg_w);
        return instr_w > opcode_w + 2 * reg_w;
    endfunction

    function automatic int unsigned opcode_lsb(input int unsigned instr_w,
                                               input int unsigned opcode_w);
        return instr_w - opcode_w;
    endfunction

    function automatic int unsigned reg_a_lsb(input int unsigned instr_w,
                                              input int unsigned opcode_w,
                                              input int unsigned reg_w);
        return instr_w - opcode_w - reg_w;
    endfunction

    function automatic int unsigned reg_b_lsb(input int unsigned instr_w,
                                              input int unsigned opcode_w,
                                              input int unsigned reg_w);
        return instr_w - opcode_w - 2 * reg_w;
    endfunction

endpackage

// File: rtl/fetch_decode_unit_ras.sv
// return_address_stack
//   Circular return-address stack. A push while full overwrites the
//   oldest entry; a pop while empty is ignored. top is the most recent
//   entry (undefined content when empty).
//   Ports: clk, reset (sync, active-low), push, pop, push_data,
//          top, full, empty.
module return_address_stack
    import fetch_decode_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_RAS_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("return_address_stack: DEPTH must be a power of 2 and >= 2");
    end

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  sp_next;
    logic [PTR_W:0]    count;

    assign sp_next = sp + 1'b1;
    assign top     = mem[sp];
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);

    // When full, sp_next already points at the oldest slot, so the
    // circular overwrite falls out of the pointer wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp <= sp_next;
            if (!full) count <= count + 1'b1;
        end else if (pop && !empty) begin
            sp    <= sp - 1'b1;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[sp_next] <= push_data;
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
//   Owns the PC, drives a 1-cycle-latency instruction memory, buffers
//   responses in a 2-entry FIFO and presents decoded fields with a
//   valid/ready handshake. Supports jump / call / return redirects with
//   flush, backed by a return-address stack.
//   Ports: clk, reset (sync, active-low);
//          jump_enable, call_enable, jump_address, link_address,
//          return_enable                      - redirect controls
//          imem_enable, imem_address, imem_instruction - memory port
//          out_valid, out_ready, out_pc, opcode, reg_a, reg_b,
//          imm_value                          - decoded output
//          ras_overflow, ras_underflow        - one-cycle RAS pulses
module fetch_decode_unit
    import fetch_decode_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned INSTR_W   = DEFAULT_INSTR_W,
    parameter int unsigned OPCODE_W  = DEFAULT_OPCODE_W,
    parameter int unsigned REG_W     = DEFAULT_REG_W,
    parameter int unsigned RAS_DEPTH = DEFAULT_RAS_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    localparam int unsigned IMM_W = imm_width(INSTR_W, OPCODE_W, REG_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jump_enable,
    input  logic                call_enable,
    input  logic [ADDR_W-1:0]   jump_address,
    input  logic [ADDR_W-1:0]   link_address,
    input  logic                return_enable,
    output logic                imem_enable,
    output logic [ADDR_W-1:0]   imem_address,
    input  logic [INSTR_W-1:0]  imem_instruction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    reg_a,
    output logic [REG_W-1:0]    reg_b,
    output logic [IMM_W-1:0]    imm_value,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    if (!fields_fit(INSTR_W, OPCODE_W, REG_W)) begin : g_bad_fields
        $error("fetch_decode_unit: INSTR_W too small for opcode + 2 register fields");
    end

    localparam int unsigned OPC_LSB = opcode_lsb(INSTR_W, OPCODE_W);
    localparam int unsigned RA_LSB  = reg_a_lsb(INSTR_W, OPCODE_W, REG_W);
    localparam int unsigned RB_LSB  = reg_b_lsb(INSTR_W, OPCODE_W, REG_W);

    logic [ADDR_W-1:0]  pc;
    logic               epoch;
    logic               inflight;
    logic               inflight_epoch;
    logic [ADDR_W-1:0]  inflight_pc;

    logic [ADDR_W-1:0]  buf_pc    [2];
    logic [INSTR_W-1:0] buf_instr [2];
    logic               head;
    logic [1:0]         count;
    logic               wr_idx;

    logic [1:0]         redir_sel;
    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic               transfer;
    logic               issue;
    logic               accept_rsp;
    logic [1:0]         occupancy;

    logic               ras_push;
    logic               ras_pop;
    logic               ras_full;
    logic               ras_empty;
    logic [ADDR_W-1:0]  ras_top;

    always_comb begin
        redir_sel = REDIR_NONE;
        if (jump_enable)        redir_sel = REDIR_JUMP;
        else if (return_enable) redir_sel = REDIR_RETURN;
    end

    assign redirect = (redir_sel != REDIR_NONE);

    always_comb begin
        target = jump_address;
        if (redir_sel == REDIR_RETURN) target = ras_empty ? RESET_PC : ras_top;
    end

    assign ras_push = jump_enable & call_enable;
    assign ras_pop  = (redir_sel == REDIR_RETURN) & ~ras_empty;

    return_address_stack #(
        .DEPTH  (RAS_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_address),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    assign out_valid = (count != 2'd0);
    assign transfer  = out_valid & out_ready;

    // Slot freed by this cycle's transfer is counted as available, which
    // is what lets a steady 1 instruction/cycle stream keep issuing.
    assign occupancy = count - {1'b0, transfer} + {1'b0, inflight};
    assign issue     = reset & ~redirect & (occupancy < 2'd2);

    // A response arriving in a redirect cycle is stale even though the
    // epoch has not toggled yet, hence the extra redirect term.
    assign accept_rsp = inflight & (inflight_epoch == epoch) & ~redirect;
    assign wr_idx     = head ^ count[0];

    assign imem_enable  = issue;
    assign imem_address = pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc             <= RESET_PC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= '0;
            head           <= 1'b0;
            count          <= 2'd0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
        end else begin
            ras_overflow  <= ras_push & ras_full;
            ras_underflow <= (redir_sel == REDIR_RETURN) & ras_empty;
            inflight      <= issue;
            if (issue) begin
                inflight_pc    <= pc;
                inflight_epoch <= epoch;
            end
            if (redirect) begin
                pc    <= target;
                epoch <= ~epoch;
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (issue)    pc   <= pc + 1'b1;
                if (transfer) head <= ~head;
                count <= count + {1'b0, accept_rsp} - {1'b0, transfer};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && accept_rsp) begin
            buf_pc[wr_idx]    <= inflight_pc;
            buf_instr[wr_idx] <= imem_instruction;
        end
    end

    logic [INSTR_W-1:0] head_instr;
    assign head_instr = buf_instr[head];

    always_comb begin
        out_pc    = '0;
        opcode    = '0;
        reg_a     = '0;
        reg_b     = '0;
        imm_value = '0;
        if (out_valid) begin
            out_pc    = buf_pc[head];
            opcode    = head_instr[OPC_LSB +: OPCODE_W];
            reg_a     = head_instr[RA_LSB +: REG_W];
            reg_b     = head_instr[RB_LSB +: REG_W];
            imm_value = head_instr[IMM_W-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit
//   Scoreboard bench: stimulus pushes the hand-derived sequence of
//   out_pc values expected to be consumed; a monitor pops and compares on
//   every transfer, and checks field stability while stalled.
module tb_fetch_decode_unit;

    logic        clk;
    logic        reset;
    logic        jump_enable;
    logic        call_enable;
    logic [15:0] jump_address;
    logic [15:0] link_address;
    logic        return_enable;
    logic        imem_enable;
    logic [15:0] imem_address;
    logic [15:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [3:0]  opcode;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [3:0]  imm_value;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] expq [$];

    fetch_decode_unit #(
        .ADDR_W    (16),
        .INSTR_W   (16),
        .OPCODE_W  (4),
        .REG_W     (4),
        .RAS_DEPTH (4),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .jump_enable      (jump_enable),
        .call_enable      (call_enable),
        .jump_address     (jump_address),
        .link_address     (link_address),
        .return_enable    (return_enable),
        .imem_enable      (imem_enable),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .opcode           (opcode),
        .reg_a            (reg_a),
        .reg_b            (reg_b),
        .imm_value        (imm_value),
        .ras_overflow     (ras_overflow),
        .ras_underflow    (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word at address a is 0x1234 + a*0x1111.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1234 + a * 16'h1111;
    endfunction

    always @(posedge clk) begin
        if (imem_enable) imem_instruction <= mem_word(imem_address);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_range(input logic [15:0] lo, input logic [15:0] hi);
        for (int a = int'(lo); a <= int'(hi); a++) expq.push_back(16'(a));
    endtask

    // Monitor / scoreboard
    initial begin
        logic        held;
        logic [15:0] held_pc;
        logic [15:0] held_fields;
        logic [15:0] e;
        held = 1'b0;
        held_pc = '0;
        held_fields = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held = 1'b0;
            end else begin
                if (held && out_valid) begin
                    check("hold_pc", 32'(out_pc), 32'(held_pc));
                    check("hold_fields", 32'({opcode, reg_a, reg_b, imm_value}), 32'(held_fields));
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_transfer: got out_pc 0x%0h, expected none", out_pc);
                    end else begin
                        e = expq.pop_front();
                        check("out_pc", 32'(out_pc), 32'(e));
                        check("fields", 32'({opcode, reg_a, reg_b, imm_value}), 32'(mem_word(e)));
                    end
                end
                held        = out_valid && !out_ready;
                held_pc     = out_pc;
                held_fields = {opcode, reg_a, reg_b, imm_value};
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        out_ready = 1'b1;
        jump_enable = 1'b0;
        call_enable = 1'b0;
        return_enable = 1'b0;
        jump_address = '0;
        link_address = '0;
        step(3);
        check("rst_imem_enable", 32'(imem_enable), 0);
        check("rst_imem_address", 32'(imem_address), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_fields", 32'({out_pc, opcode, reg_a, reg_b, imm_value}), 0);
        check("rst_flags", 32'({ras_overflow, ras_underflow}), 0);

        // Release and stream; stall 5 cycles mid-stream.
        exp_range(16'h0000, 16'h000B);
        reset = 1'b1;
        step(1);
        check("first_issue_enable", 32'(imem_enable), 1);
        check("first_issue_addr", 32'(imem_address), 1);
        check("not_yet_valid", 32'(out_valid), 0);
        step(1);
        check("latency_valid", 32'(out_valid), 1);
        check("first_pc", 32'(out_pc), 0);
        check("first_opcode", 32'(opcode), 1);
        check("first_reg_a", 32'(reg_a), 2);
        check("first_reg_b", 32'(reg_b), 3);
        check("first_imm", 32'(imm_value), 4);
        step(6);
        out_ready = 1'b0;
        step(2);
        check("stall_no_fetch", 32'(imem_enable), 0);
        check("stall_valid", 32'(out_valid), 1);
        check("stall_head", 32'(out_pc), 6);
        step(3);
        out_ready = 1'b1;
        step(5);

        // Jump while streaming: head 0x0B consumed, in-flight 0x0C dropped.
        jump_enable = 1'b1;
        jump_address = 16'h0040;
        step(1);
        jump_enable = 1'b0;
        step(2);
        check("jump_head", 32'(out_pc), 32'h40);
        exp_range(16'h0040, 16'h0043);
        step(4);

        // Stall until two entries are buffered, then call: both dropped.
        out_ready = 1'b0;
        step(1);
        check("full_no_fetch", 32'(imem_enable), 0);
        jump_enable = 1'b1;
        call_enable = 1'b1;
        jump_address = 16'h0100;
        link_address = 16'h0011;
        step(1);
        jump_enable = 1'b0;
        call_enable = 1'b0;
        out_ready = 1'b1;
        step(2);
        expq.push_back(16'h0100);
        return_enable = 1'b1;
        step(1);
        return_enable = 1'b0;
        step(2);
        check("return_head", 32'(out_pc), 32'h11);

        // RAS now empty: return underflows to RESET_PC.
        expq.push_back(16'h0011);
        return_enable = 1'b1;
        step(1);
        return_enable = 1'b0;
        check("underflow_pulse", 32'(ras_underflow), 1);
        step(1);
        check("underflow_clear", 32'(ras_underflow), 0);
        step(1);

        // Five back-to-back calls into a 4-deep RAS.
        expq.push_back(16'h0000);
        for (int k = 1; k <= 5; k++) begin
            jump_enable = 1'b1;
            call_enable = 1'b1;
            jump_address = 16'(16'h0200 + k * 16);
            link_address = 16'(k);
            step(1);
            if (k == 4) check("no_overflow_4", 32'(ras_overflow), 0);
            if (k == 5) check("overflow_pulse", 32'(ras_overflow), 1);
        end
        jump_enable = 1'b0;
        call_enable = 1'b0;
        step(1);
        check("overflow_clear", 32'(ras_overflow), 0);
        step(1);

        // Returns yield 5,4,3,2 then underflow to 0.
        expq.push_back(16'h0250);
        for (int i = 0; i < 5; i++) begin
            return_enable = 1'b1;
            step(1);
            return_enable = 1'b0;
            check("return_underflow", 32'(ras_underflow), (i == 4) ? 1 : 0);
            expq.push_back((i < 4) ? 16'(5 - i) : 16'h0000);
            step(2);
        end
        exp_range(16'h0001, 16'h0003);
        step(3);

        // PC wrap, then reset mid-stall.
        jump_enable = 1'b1;
        jump_address = 16'hFFFE;
        step(1);
        jump_enable = 1'b0;
        step(2);
        expq.push_back(16'hFFFE);
        expq.push_back(16'hFFFF);
        expq.push_back(16'h0000);
        expq.push_back(16'h0001);
        step(4);
        out_ready = 1'b0;
        step(2);
        check("wrap_stall_valid", 32'(out_valid), 1);
        check("wrap_stall_head", 32'(out_pc), 2);
        reset = 1'b0;
        step(1);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_enable", 32'(imem_enable), 0);
        check("midrst_fields", 32'({out_pc, opcode, reg_a, reg_b, imm_value}), 0);
        step(1);
        reset = 1'b1;
        out_ready = 1'b1;
        expq.push_back(16'h0000);
        expq.push_back(16'h0001);
        step(4);
        out_ready = 1'b0;
        step(2);
        check("scoreboard_drained", 32'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
